// File: rtl/dram_ctrl_if.sv
// -----------------------------------------------------------------------------
// dram_ctrl_if
// Bus bundle between the bus controller (master side) and the DRAM sequencer
// (slave side), plus the strobes the sequencer drives toward the SIMM sockets.
//
// Signals:
//   ramCEn     master->slave  DRAM select, active-low
//   cpuRWn     master->slave  1 = read, 0 = write
//   cpuSIZ     master->slave  transfer size, 00 = 4 bytes, 01 = 1, 10 = 2, 11 = 3
//   cpuAddrLo  master->slave  CPU A[1:0] (byte offset)
//   cpuAddr    master->slave  CPU longword address; row = upper ROW_W bits
//   dramAddr   slave->master  multiplexed row/column address
//   dramRASn   slave->master  row strobe, active-low
//   dramCASn   slave->master  column strobes, [3] = D31:24 ... [0] = D7:0
//   dramWEn    slave->master  write enable, active-low
//   ramACKn    slave->master  cycle acknowledge, active-low
// -----------------------------------------------------------------------------
interface dram_ctrl_if #(
    parameter int ROW_W = 11
);
    logic                 ramCEn;
    logic                 cpuRWn;
    logic [1:0]           cpuSIZ;
    logic [1:0]           cpuAddrLo;
    logic [2*ROW_W-1:0]   cpuAddr;
    logic [ROW_W-1:0]     dramAddr;
    logic                 dramRASn;
    logic [3:0]           dramCASn;
    logic                 dramWEn;
    logic                 ramACKn;

    modport master (
        output ramCEn, cpuRWn, cpuSIZ, cpuAddrLo, cpuAddr,
        input  dramAddr, dramRASn, dramCASn, dramWEn, ramACKn
    );

    modport slave (
        input  ramCEn, cpuRWn, cpuSIZ, cpuAddrLo, cpuAddr,
        output dramAddr, dramRASn, dramCASn, dramWEn, ramACKn
    );
endinterface

// File: rtl/dram_ctrl.sv
// -----------------------------------------------------------------------------
// dram_ctrl
// Sequences the DRAM array for the bus controller: turns a ramCEn select into
// a RAS / column-switch / CAS / acknowledge cycle with per-byte CAS lanes, and
// interleaves CAS-before-RAS refresh from a free-running interval timer.
// A pending refresh always wins over a CPU access at the decision point.
//
// Ports:
//   sysClk      in   system clock
//   sysRESETn   in   asynchronous active-low reset
//   bus         slave modport of dram_ctrl_if (CPU side in, DRAM strobes out)
//   refOverrun  out  sticky: timer expired while a refresh was still pending
//                    (only when DRAM_REFRESH_OVERRUN_EN is defined)
//
// Optional feature macro: DRAM_REFRESH_OVERRUN_EN
// -----------------------------------------------------------------------------
module dram_ctrl #(
    parameter int ROW_W   = 11,
    parameter int RAS_CYC = 2,
    parameter int CAS_CYC = 2,
    parameter int PRE_CYC = 2,
    parameter int REF_DIV = 390
) (
    input  logic        sysClk,
    input  logic        sysRESETn,
    dram_ctrl_if.slave  bus
`ifdef DRAM_REFRESH_OVERRUN_EN
    ,
    output logic        refOverrun
`endif
);
    localparam int CYC_MAX = (RAS_CYC > CAS_CYC) ?
                             ((RAS_CYC > PRE_CYC) ? RAS_CYC : PRE_CYC) :
                             ((CAS_CYC > PRE_CYC) ? CAS_CYC : PRE_CYC);
    localparam int CNT_W = $clog2(CYC_MAX + 1);
    localparam int TMR_W = $clog2(REF_DIV + 1);

    localparam logic [CNT_W-1:0] RAS_LAST = CNT_W'(RAS_CYC - 1);
    localparam logic [CNT_W-1:0] CAS_LAST = CNT_W'(CAS_CYC - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(REF_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RAS, S_CAS, S_ACK, S_PRE, S_REF0, S_REF1, S_REF2, S_REF3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               ref_pend_q, ref_pend_d;
    logic               ras_n_q, ras_n_d;
    logic [3:0]         cas_n_q, cas_n_d;
    logic               we_n_q, we_n_d;
    logic               ack_n_q, ack_n_d;
    logic               col_sel_q, col_sel_d;
    logic [ROW_W-1:0]   col_q, col_d;
    logic [3:0]         mask_q, mask_d;
    logic               rd_q, rd_d;

    logic               ref_expire, ref_req, decide, release_all, go_ref;
    logic [3:0]         lane_mask;
    logic [2:0]         size_n;

    // Byte offset b drives lane [3-b]; the run of lanes is clipped at offset 3.
    always_comb begin
        lane_mask = 4'h0;
        size_n    = (bus.cpuSIZ == 2'b00) ? 3'd4 : {1'b0, bus.cpuSIZ};
        for (int b = 0; b < 4; b++) begin
            lane_mask[3-b] = (b >= int'(bus.cpuAddrLo)) &&
                             (b <  int'(bus.cpuAddrLo) + int'(size_n));
        end
    end

    always_comb begin
        // NOTE: every _d starts from its held value so no branch of the case can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        ras_n_d     = ras_n_q;
        cas_n_d     = cas_n_q;
        we_n_d      = we_n_q;
        ack_n_d     = ack_n_q;
        col_sel_d   = col_sel_q;
        col_d       = col_q;
        mask_d      = mask_q;
        rd_d        = rd_q;
        decide      = 1'b0;
        release_all = 1'b0;
        go_ref      = 1'b0;

        // A timer expiry in this clock already counts as a request, so refresh
        // beats a CPU select that arrives in the same clock.
        ref_expire = (tmr_q == '0);
        ref_req    = ref_pend_q | ref_expire;
        tmr_d      = ref_expire ? TMR_LOAD : tmr_q - 1'b1;

        case (state_q)
            S_IDLE: decide = 1'b1;
            S_RAS: begin
                if (bus.ramCEn) begin
                    release_all = 1'b1;
                end else begin
                    if (cnt_q == '0) begin
                        col_sel_d = 1'b1;
                        we_n_d    = rd_q;
                    end
                    if (cnt_q == RAS_LAST) begin
                        state_d = S_CAS;
                        cnt_d   = '0;
                        cas_n_d = rd_q ? 4'h0 : ~mask_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_CAS: begin
                if (bus.ramCEn) begin
                    release_all = 1'b1;
                end else if (cnt_q == CAS_LAST) begin
                    ack_n_d = 1'b0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_ACK: release_all = bus.ramCEn;
            S_PRE: begin
                if (cnt_q == PRE_LAST) decide = 1'b1;
                else                   cnt_d  = cnt_q + 1'b1;
            end
            S_REF0: begin
                state_d = S_REF1;
                ras_n_d = 1'b0;
            end
            S_REF1: state_d = S_REF2;
            S_REF2: begin
                state_d = S_REF3;
                ras_n_d = 1'b1;
                cas_n_d = 4'hF;
            end
            S_REF3: begin
                state_d = S_PRE;
                cnt_d   = '0;
            end
            default: begin
                state_d   = S_IDLE;
                ras_n_d   = 1'b1;
                cas_n_d   = 4'hF;
                we_n_d    = 1'b1;
                ack_n_d   = 1'b1;
                col_sel_d = 1'b0;
            end
        endcase

        // Normal end of cycle and CPU abort share the same release into precharge.
        if (release_all) begin
            state_d   = S_PRE;
            cnt_d     = '0;
            ras_n_d   = 1'b1;
            cas_n_d   = 4'hF;
            we_n_d    = 1'b1;
            ack_n_d   = 1'b1;
            col_sel_d = 1'b0;
        end

        // IDLE and the last precharge clock share one arbitration point.
        if (decide) begin
            state_d = S_IDLE;
            if (ref_req) begin
                state_d = S_REF0;
                cas_n_d = 4'h0;
                go_ref  = 1'b1;
            end else if (!bus.ramCEn) begin
                state_d   = S_RAS;
                cnt_d     = '0;
                ras_n_d   = 1'b0;
                col_sel_d = 1'b0;
                rd_d      = bus.cpuRWn;
                mask_d    = lane_mask;
                col_d     = bus.cpuAddr[ROW_W-1:0];
            end
        end

        // Serving a refresh clears the pending flag unless a fresh expiry
        // lands while an older request is still the one being served.
        if (go_ref) ref_pend_d = ref_pend_q & ref_expire;
        else        ref_pend_d = ref_pend_q | ref_expire;
    end

`ifdef DRAM_REFRESH_OVERRUN_EN
    logic ovr_q, ovr_d;
    always_comb ovr_d = ovr_q | (ref_expire & ref_pend_q);
    assign refOverrun = ovr_q;
`endif

    always_ff @(posedge sysClk or negedge sysRESETn) begin
        if (!sysRESETn) begin
            // NOTE: reset drops every strobe immediately; the datapath latches are reset too so no X reaches the pins.
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmr_q      <= TMR_LOAD;
            ref_pend_q <= 1'b0;
            ras_n_q    <= 1'b1;
            cas_n_q    <= 4'hF;
            we_n_q     <= 1'b1;
            ack_n_q    <= 1'b1;
            col_sel_q  <= 1'b0;
            col_q      <= '0;
            mask_q     <= 4'h0;
            rd_q       <= 1'b1;
`ifdef DRAM_REFRESH_OVERRUN_EN
            ovr_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tmr_q      <= tmr_d;
            ref_pend_q <= ref_pend_d;
            ras_n_q    <= ras_n_d;
            cas_n_q    <= cas_n_d;
            we_n_q     <= we_n_d;
            ack_n_q    <= ack_n_d;
            col_sel_q  <= col_sel_d;
            col_q      <= col_d;
            mask_q     <= mask_d;
            rd_q       <= rd_d;
`ifdef DRAM_REFRESH_OVERRUN_EN
            ovr_q      <= ovr_d;
`endif
        end
    end

    // The row phase passes the CPU row through a registered select: the CPU
    // holds its address for the whole select, and the row is valid from reset.
    assign bus.dramAddr = col_sel_q ? col_q : bus.cpuAddr[2*ROW_W-1:ROW_W];
    assign bus.dramRASn = ras_n_q;
    assign bus.dramCASn = cas_n_q;
    assign bus.dramWEn  = we_n_q;
    assign bus.ramACKn  = ack_n_q;
endmodule

// File: tb/tb_dram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dram_ctrl
// Directed bench for dram_ctrl. Expected access results are queued when an
// access is driven and popped when the DUT drives its CAS lanes.
// -----------------------------------------------------------------------------
module tb_dram_ctrl;
    localparam int ROW_W   = 11;
    localparam int RAS_CYC = 2;
    localparam int CAS_CYC = 2;
    localparam int PRE_CYC = 2;
`ifdef DRAM_REFRESH_OVERRUN_EN
    localparam int REF_DIV = 100;
`else
    localparam int REF_DIV = 390;
`endif

    typedef struct {
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] col;
        logic [3:0]       casn;
        logic             wen;
    } exp_t;

    logic sysClk    = 1'b0;
    logic sysRESETn = 1'b0;
    always #5 sysClk = ~sysClk;

    dram_ctrl_if #(.ROW_W(ROW_W)) bus ();
`ifdef DRAM_REFRESH_OVERRUN_EN
    logic refOverrun;
`endif

    dram_ctrl #(
        .ROW_W(ROW_W), .RAS_CYC(RAS_CYC), .CAS_CYC(CAS_CYC),
        .PRE_CYC(PRE_CYC), .REF_DIV(REF_DIV)
    ) dut (
        .sysClk    (sysClk),
        .sysRESETn (sysRESETn),
        .bus       (bus)
`ifdef DRAM_REFRESH_OVERRUN_EN
        ,
        .refOverrun(refOverrun)
`endif
    );

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysClk);
        #1;
        cyc++;
    endtask

    task automatic check_idle_pins(input string tag);
        check({tag, "_ras"}, bus.dramRASn, 1'b1);
        check({tag, "_cas"}, bus.dramCASn, 4'hF);
        check({tag, "_we"},  bus.dramWEn,  1'b1);
        check({tag, "_ack"}, bus.ramACKn,  1'b1);
    endtask

    task automatic do_reset();
        logic [2*ROW_W-1:0] a;
        a             = 22'h1CA3F7;
        bus.ramCEn    = 1'b1;
        bus.cpuRWn    = 1'b1;
        bus.cpuSIZ    = 2'b00;
        bus.cpuAddrLo = 2'b00;
        bus.cpuAddr   = a;
        sysRESETn     = 1'b0;
        repeat (2) @(posedge sysClk);
        #1;
        check_idle_pins("reset");
        check("reset_addr_row", bus.dramAddr, a[2*ROW_W-1:ROW_W]);
`ifdef DRAM_REFRESH_OVERRUN_EN
        check("reset_overrun", refOverrun, 1'b0);
`endif
        sysRESETn = 1'b1;
        cyc       = 0;
    endtask

    // One complete access; returns the cycles at which RAS and ACK were seen.
    task automatic do_access(input logic rw, input logic [1:0] siz, input logic [1:0] lo,
                             input logic [2*ROW_W-1:0] addr, input logic [3:0] exp_casn,
                             input int hold, output int ras_c, output int ack_c);
        exp_t e;
        int   n;
        e.row  = addr[2*ROW_W-1:ROW_W];
        e.col  = addr[ROW_W-1:0];
        e.casn = rw ? 4'h0 : exp_casn;
        e.wen  = rw;
        sb_q.push_back(e);
        bus.cpuRWn    = rw;
        bus.cpuSIZ    = siz;
        bus.cpuAddrLo = lo;
        bus.cpuAddr   = addr;
        bus.ramCEn    = 1'b0;
        for (n = 0; n < 20; n++) begin
            tick();
            if (bus.dramRASn === 1'b0) break;
        end
        check("ras_start", bus.dramRASn, 1'b0);
        ras_c = cyc;
        check("row_addr", bus.dramAddr, e.row);
        check("row_cas_idle", bus.dramCASn, 4'hF);
        tick();
        check("col_addr", bus.dramAddr, e.col);
        check("col_we", bus.dramWEn, e.wen);
        repeat (RAS_CYC - 1) tick();
        e = sb_q.pop_front();
        check("cas_lanes", bus.dramCASn, e.casn);
        check("cas_addr", bus.dramAddr, e.col);
        check("cas_no_ack", bus.ramACKn, 1'b1);
        repeat (CAS_CYC) tick();
        check("ack", bus.ramACKn, 1'b0);
        ack_c = cyc;
        check("ack_ras", bus.dramRASn, 1'b0);
        check("ack_cas", bus.dramCASn, e.casn);
        repeat (hold) tick();
        bus.ramCEn = 1'b1;
        tick();
        check_idle_pins("release");
    endtask

    typedef struct {
        logic [1:0] siz;
        logic [1:0] lo;
        logic [3:0] casn;
    } lane_t;

    lane_t lanes[8] = '{
        '{2'b00, 2'd0, 4'b0000}, '{2'b01, 2'd2, 4'b1101},
        '{2'b10, 2'd3, 4'b1110}, '{2'b11, 2'd1, 4'b1000},
        '{2'b10, 2'd0, 4'b0011}, '{2'b11, 2'd2, 4'b1100},
        '{2'b00, 2'd2, 4'b1100}, '{2'b01, 2'd0, 4'b0111}
    };

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int s, ras_c, ack_c, ras2, ack2, hi, n;

        // Longword read with exact cycle positions, then a byte write back-to-back.
        do_reset();
        tick();
        tick();
        s = cyc;
        do_access(1'b1, 2'b00, 2'd0, 22'h155AAA, 4'h0, 3, ras_c, ack_c);
        check("t1_ras_cycle", ras_c - s, 1);
        check("t1_ack_cycle", ack_c - s, 5);
        check("t1_release_cycle", cyc - s, 9);
        do_access(1'b0, 2'b01, 2'd1, 22'h2AB155, 4'b1011, 0, ras2, ack2);
        check("t1_precharge", (ras2 >= s + 11), 1'b1);

        // Lane masks for writes.
        foreach (lanes[i]) begin
            do_reset();
            do_access(1'b0, lanes[i].siz, lanes[i].lo, 22'($urandom),
                      lanes[i].casn, 1, ras_c, ack_c);
        end

        // Abort during CAS.
        do_reset();
        bus.cpuRWn  = 1'b1;
        bus.cpuAddr = 22'h0F0F0F;
        bus.ramCEn  = 1'b0;
        repeat (1 + RAS_CYC) tick();
        check("abort_cas_active", bus.dramCASn, 4'h0);
        bus.ramCEn = 1'b1;
        tick();
        check_idle_pins("abort");
        bus.ramCEn = 1'b0;
        hi = 1;
        for (n = 0; n < 20; n++) begin
            tick();
            if (bus.dramRASn === 1'b0) break;
            hi++;
        end
        check("abort_ack_stays_high_until_ras", bus.ramACKn, 1'b1);
        check("abort_precharge", (hi >= PRE_CYC), 1'b1);

        // Refresh expiry in the same clock as ramCEn going low.
        do_reset();
        repeat (REF_DIV - 1) tick();
        check("pre_expiry_cas", bus.dramCASn, 4'hF);
        bus.cpuRWn  = 1'b1;
        bus.cpuAddr = 22'h3FF001;
        bus.ramCEn  = 1'b0;
        tick();
        check("cbr_ref0_cas", bus.dramCASn, 4'h0);
        check("cbr_ref0_ras", bus.dramRASn, 1'b1);
        tick();
        check("cbr_ref1_ras", bus.dramRASn, 1'b0);
        check("cbr_ref1_we", bus.dramWEn, 1'b1);
        tick();
        check("cbr_ref2_ras", bus.dramRASn, 1'b0);
        tick();
        check("cbr_ref3_ras", bus.dramRASn, 1'b1);
        check("cbr_ref3_cas", bus.dramCASn, 4'hF);
        hi = 0;
        for (n = 0; n < 20; n++) begin
            tick();
            if (bus.dramRASn === 1'b0) break;
            hi++;
        end
        check("cbr_cpu_ras", bus.dramRASn, 1'b0);
        check("cbr_cpu_cas_idle", bus.dramCASn, 4'hF);
        check("cbr_cpu_row", bus.dramAddr, 11'h7FE);
        check("cbr_precharge", (hi >= PRE_CYC), 1'b1);

        // Long stall in ACK leaves a refresh pending that runs right after PRE.
        do_reset();
        do_access(1'b1, 2'b00, 2'd0, 22'h12345, 4'h0, 400, ras_c, ack_c);
        repeat (PRE_CYC) tick();
        check("stall_ref0_cas", bus.dramCASn, 4'h0);
        check("stall_ref0_ras", bus.dramRASn, 1'b1);
        tick();
        check("stall_ref1_ras", bus.dramRASn, 1'b0);
`ifdef DRAM_REFRESH_OVERRUN_EN
        check("stall_overrun", refOverrun, 1'b1);
`endif

        // Reset pulsed during REF1.
        do_reset();
        repeat (REF_DIV + 1) tick();
        check("ref1_ras", bus.dramRASn, 1'b0);
        check("ref1_cas", bus.dramCASn, 4'h0);
        #2;
        sysRESETn = 1'b0;
        #1;
        check_idle_pins("async_reset");
        @(posedge sysClk);
        #1;
        sysRESETn = 1'b1;
        cyc       = 0;
        do_access(1'b1, 2'b00, 2'd0, 22'h2A0011, 4'h0, 0, ras_c, ack_c);
        check("post_reset_ras_cycle", ras_c, 1);
        while (cyc < REF_DIV - 1) tick();
        check("reload_no_early_ref", bus.dramCASn, 4'hF);
        tick();
        check("reload_ref0_cas", bus.dramCASn, 4'h0);
        check("reload_ref0_ras", bus.dramRASn, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
